// File: rtl/fifo_stream_reader.sv
// Read-side adapter for a 1-cycle-latency FIFO: pops into a 3-entry in-order
// buffer and presents a valid/ready stream framed into bursts of BurstLen beats.
module fifo_stream_reader #(
  parameter  int Width    = 8,
  parameter  int BurstLen = 4,
  localparam int CntW     = $clog2(BurstLen) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             fifo_empty,
  input  logic             fifo_wr_acc,
  input  logic [Width-1:0] fifo_d_out,
  output logic             fifo_rd_en,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [Width-1:0] m_data,
  output logic             m_last,
  output logic [CntW-1:0]  beat_cnt,
  output logic [15:0]      burst_cnt
);

  logic [Width-1:0] buf_q [3];
  logic [Width-1:0] buf_d [3];
  logic [1:0]       occ_q, occ_d, wr_idx;
  logic             pend_q, pend_d;
  logic [CntW-1:0]  beat_q, beat_d;
  logic [15:0]      burst_q, burst_d;
  logic [2:0]       inflight;
  logic             pop_acc, hs;

  // Words already committed (buffered or arriving next edge) bound new pops,
  // so the request never depends on m_ready.
  assign inflight   = {1'b0, occ_q} + {2'b0, pend_q};
  assign fifo_rd_en = rst & enable & ~fifo_empty & (inflight <= 3'd2);
  assign pop_acc    = fifo_rd_en & ~fifo_empty & ~fifo_wr_acc;

  assign m_valid   = (occ_q != 2'd0);
  assign m_data    = buf_q[0];
  assign m_last    = m_valid & (beat_q == CntW'(BurstLen - 1));
  assign hs        = m_valid & m_ready;
  assign beat_cnt  = beat_q;
  assign burst_cnt = burst_q;

  // Tail slot as seen after this cycle's head removal.
  assign wr_idx = occ_q - {1'b0, hs};

  always_comb begin
    buf_d   = buf_q;
    occ_d   = occ_q + {1'b0, pend_q} - {1'b0, hs};
    pend_d  = pop_acc;
    beat_d  = beat_q;
    burst_d = burst_q;
    if (hs) begin
      buf_d[0] = buf_q[1];
      buf_d[1] = buf_q[2];
      if (m_last) begin
        beat_d  = '0;
        burst_d = burst_q + 16'd1;
      end else begin
        beat_d = beat_q + CntW'(1);
      end
    end
    if (pend_q && wr_idx != 2'd3) buf_d[wr_idx] = fifo_d_out;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++) buf_q[i] <= '0;
      occ_q   <= '0;
      pend_q  <= 1'b0;
      beat_q  <= '0;
      burst_q <= '0;
    end else begin
      buf_q   <= buf_d;
      occ_q   <= occ_d;
      pend_q  <= pend_d;
      beat_q  <= beat_d;
      burst_q <= burst_d;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(pend_q && occ_q == 2'd3 && !hs));

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed + random bench for fifo_stream_reader against a queue-based model of
// the FIFO and of the word stream it should deliver.
module tb_fifo_stream_reader;
  localparam int W  = 8;
  localparam int BL = 4;
  localparam int CW = $clog2(BL) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic          fifo_empty = 1'b1;
  logic          fifo_wr_acc = 1'b0;
  logic [W-1:0]  fifo_d_out = '0;
  logic          m_ready = 1'b0;
  logic          fifo_rd_en, m_valid, m_last;
  logic [W-1:0]  m_data;
  logic [CW-1:0] beat_cnt;
  logic [15:0]   burst_cnt;

  fifo_stream_reader #(.Width(W), .BurstLen(BL)) dut (
    .clk(clk), .rst(rst), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_wr_acc(fifo_wr_acc), .fifo_d_out(fifo_d_out), .fifo_rd_en(fifo_rd_en),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .beat_cnt(beat_cnt), .burst_cnt(burst_cnt)
  );

  always #5 clk = ~clk;

  logic [W-1:0] fq[$];
  logic [W-1:0] sb[$];
  logic [W-1:0] outq[$];
  bit           lastq[$];
  logic [W-1:0] wr_word;
  int  inflight, beat_idx, bursts, pops, hs_count, cyc;
  int  first_pop, first_valid, last_hs, gaps;
  bit  prev_acc;
  int  errors, checks;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic preload(logic [W-1:0] start, int n);
    fq.delete();
    for (int i = 0; i < n; i++) fq.push_back(start + W'(i));
  endtask

  task automatic reset_stats();
    pops = 0; hs_count = 0; first_pop = -1; first_valid = -1;
    last_hs = -1; gaps = 0;
    outq.delete(); lastq.delete();
  endtask

  // Anything popped but not yet delivered is lost on reset.
  task automatic do_reset();
    rst = 1'b0;
    fifo_empty = (fq.size() == 0);
    #1;
    inflight = 0; sb.delete(); beat_idx = 0; bursts = 0; prev_acc = 1'b0;
    chk("rst_rd_en",   fifo_rd_en, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_last",  m_last, 0);
    chk("rst_m_data",  m_data, 0);
    chk("rst_beat",    beat_cnt, 0);
    chk("rst_burst",   burst_cnt, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // One clock: check outputs against the model, then advance FIFO and model.
  task automatic cycle();
    bit acc, hs;
    acc = 1'b0; hs = 1'b0;
    fifo_empty = (fq.size() == 0);
    #1;
    if (rst) begin
      chk("rd_en", fifo_rd_en, (enable && !fifo_empty && inflight <= 2));
      chk("m_valid", m_valid, ((inflight - int'(prev_acc)) > 0));
      if (m_valid) begin
        if (first_valid < 0) first_valid = cyc;
        if (sb.size() == 0) chk("word_pending", sb.size(), 1);
        else chk("m_data", m_data, sb[0]);
        chk("m_last", m_last, (beat_idx == BL - 1));
        chk("beat_cnt", beat_cnt, beat_idx);
        chk("burst_cnt", burst_cnt, bursts);
      end
      acc = fifo_rd_en && !fifo_empty && !fifo_wr_acc;
      hs  = m_valid && m_ready;
      if (hs) begin outq.push_back(m_data); lastq.push_back(m_last); end
    end
    @(posedge clk);
    #1;
    if (fifo_wr_acc) fq.push_back(wr_word);
    if (hs) begin
      if (sb.size() > 0) sb.delete(0);
      inflight--; hs_count++;
      if (last_hs >= 0 && cyc - last_hs > 1) gaps++;
      last_hs = cyc;
      if (beat_idx == BL - 1) begin beat_idx = 0; bursts = (bursts + 1) % 65536; end
      else beat_idx++;
    end
    if (acc) begin
      fifo_d_out = fq.pop_front();
      sb.push_back(fifo_d_out);
      inflight++; pops++;
      if (first_pop < 0) first_pop = cyc;
    end
    prev_acc = acc;
    fifo_wr_acc = 1'b0;
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    errors = 0; checks = 0; cyc = 0;
    inflight = 0; beat_idx = 0; bursts = 0; prev_acc = 1'b0; wr_word = '0;
    reset_stats();

    // Reset holds everything quiet even with data available and enable high.
    enable = 1'b1; m_ready = 1'b1;
    preload(8'h10, 8);
    do_reset();

    // Streaming at full rate.
    reset_stats();
    for (int n = 0; n < 16; n++) cycle();
    chk("stream_latency", first_valid - first_pop, 2);
    chk("stream_beats", hs_count, 8);
    chk("stream_gaps", gaps, 0);
    if (outq.size() == 8) begin
      chk("stream_last_3", lastq[3], 1);
      chk("stream_data_3", outq[3], 8'h13);
      chk("stream_last_7", lastq[7], 1);
      chk("stream_data_7", outq[7], 8'h17);
    end
    chk("stream_bursts", burst_cnt, 2);

    // Backpressure: three words fill the pipe, then pops stop.
    preload(8'h10, 8);
    do_reset();
    reset_stats();
    m_ready = 1'b0;
    for (int n = 0; n < 8; n++) cycle();
    #1;
    chk("bp_pops", pops, 3);
    chk("bp_rd_en", fifo_rd_en, 0);
    chk("bp_head", m_data, 8'h10);
    m_ready = 1'b1;
    for (int n = 0; n < 20; n++) cycle();
    chk("bp_beats", outq.size(), 8);
    chk("bp_gaps", gaps, 0);
    for (int i = 0; i < outq.size(); i++) chk("bp_order", outq[i], 8'h10 + W'(i));

    // Write collision on the second pop request.
    preload(8'h10, 3);
    do_reset();
    reset_stats();
    cycle();
    fifo_wr_acc = 1'b1; wr_word = 8'h13;
    cycle();
    chk("coll_pops", pops, 1);
    for (int n = 0; n < 10; n++) cycle();
    chk("coll_beats", outq.size(), 4);
    if (outq.size() >= 3) begin
      chk("coll_d0", outq[0], 8'h10);
      chk("coll_d1", outq[1], 8'h11);
      chk("coll_d2", outq[2], 8'h12);
    end

    // enable drop right after the second accepted pop.
    preload(8'h10, 8);
    do_reset();
    reset_stats();
    for (int n = 0; n < 10 && pops < 2; n++) cycle();
    chk("en_pops", pops, 2);
    enable = 1'b0;
    for (int n = 0; n < 8; n++) cycle();
    #1;
    chk("en_beats", hs_count, 2);
    chk("en_rd_en", fifo_rd_en, 0);
    enable = 1'b1;
    for (int n = 0; n < 10 && hs_count < 3; n++) cycle();
    if (outq.size() >= 3) chk("en_resume", outq[2], 8'h12);
    else chk("en_resume_beats", outq.size(), 3);

    // Reset in the middle of a burst.
    preload(8'h10, 12);
    do_reset();
    reset_stats();
    for (int n = 0; n < 10 && hs_count < 2; n++) cycle();
    chk("mid_beats", hs_count, 2);
    do_reset();
    reset_stats();
    for (int n = 0; n < 20 && hs_count < 4; n++) cycle();
    chk("mid_after_beats", outq.size(), 4);
    if (lastq.size() >= 4) begin
      chk("mid_last0", lastq[0], 0);
      chk("mid_last3", lastq[3], 1);
    end

    // Random traffic: backpressure, enable, write collisions, empty FIFO.
    preload(8'h40, 4);
    do_reset();
    reset_stats();
    for (int n = 0; n < 800; n++) begin
      m_ready = ($urandom_range(0, 3) != 0);
      enable  = ($urandom_range(0, 5) != 0);
      if ($urandom_range(0, 2) == 0) begin
        fifo_wr_acc = 1'b1;
        wr_word = W'($urandom);
      end
      cycle();
      chk("rand_inflight_le3", (inflight <= 3), 1);
    end
    m_ready = 1'b1; enable = 1'b0;
    for (int n = 0; n < 10; n++) cycle();
    chk("rand_drained", m_valid, 0);
    chk("rand_bursts", burst_cnt, bursts);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
